// File: rtl/display_scan_pkg.sv
// Shared types and segment encodings for the display scan controller.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package display_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    UPDATE
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_converter.sv
// Multi-cycle shift-add-3 binary to BCD converter with start/done handshake.
// The input value is captured on the edge that accepts start; later input changes are ignored.
module bcd_converter
  import display_scan_pkg::*;
#(
  parameter int unsigned Size      = 5,
  parameter int unsigned BcdDigits = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [Size-1:0]        data,
  input  logic                   sign,
  output logic                   busy,
  output logic                   done,
  output logic [4*BcdDigits-1:0] bcd,
  output logic                   bcd_sign,
  output logic [Size:0]          stored
);

  localparam int unsigned CntW = $clog2(Size + 1);

  conv_state_t            state, state_nxt;
  logic [Size-1:0]        mag;
  logic [4*BcdDigits-1:0] bcd_sr;
  logic [4*BcdDigits-1:0] bcd_adj;
  logic [CntW-1:0]        cnt;

  always_comb begin
    bcd_adj = bcd_sr;
    for (int unsigned i = 0; i < BcdDigits; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (cnt == CntW'(Size - 1)) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      stored <= '0;
      mag    <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            stored <= {sign, data};
            mag    <= data;
          end
        end
        LOAD: begin
          bcd_sr <= '0;
          cnt    <= '0;
        end
        SHIFT: begin
          bcd_sr <= {bcd_adj[4*BcdDigits-2:0], mag[Size-1]};
          mag    <= mag << 1;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == UPDATE);
  assign bcd      = bcd_sr;
  assign bcd_sign = stored[Size];

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed common-anode seven-segment scan controller with sign position.
// Optional LEADING_ZERO_BLANK_EN blanks BCD positions above the most significant non-zero digit.
module display_scan_controller
  import display_scan_pkg::*;
#(
  parameter int unsigned Size           = 5,
  parameter int unsigned Digits         = 3,
  parameter int unsigned ClockPeriod_ns = 20,
  parameter int unsigned ScanPeriod_ns  = 1_000_000
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [Size-1:0]   Data,
  input  logic              SigneBit,
  output logic [6:0]        Segments,
  output logic [Digits-1:0] DigitSel,
  output logic              Busy
);

  localparam int unsigned BcdDigits = Digits - 1;
  localparam int unsigned ScanTicks = ScanPeriod_ns / ClockPeriod_ns;
  localparam int unsigned PreW      = $clog2(ScanTicks);
  localparam int unsigned IdxW      = $clog2(Digits);

  logic                   start, done;
  logic [4*BcdDigits-1:0] bcd;
  logic                   bcd_sign;
  logic [Size:0]          stored;

  logic                   valid;
  logic [4*BcdDigits-1:0] disp_bcd;
  logic                   disp_sign;
  logic [BcdDigits-1:0]   lead;

  logic [PreW-1:0]        presc, presc_nxt;
  logic [IdxW-1:0]        idx, idx_nxt;
  logic                   presc_tc;
  logic [6:0]             seg_sel;

  assign start = !valid || ({SigneBit, Data} != stored);

  bcd_converter #(
    .Size      (Size),
    .BcdDigits (BcdDigits)
  ) u_conv (
    .clk      (Clock),
    .rst      (Reset),
    .start    (start),
    .data     (Data),
    .sign     (SigneBit),
    .busy     (Busy),
    .done     (done),
    .bcd      (bcd),
    .bcd_sign (bcd_sign),
    .stored   (stored)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // Walk from the top BCD position down; position 0 is never blanked.
  always_comb begin
    lead       = '0;
    upper_zero = 1'b1;
    for (int unsigned k = 0; k < BcdDigits; k++) begin
      upper_zero = upper_zero && (disp_bcd[4*(BcdDigits-1-k) +: 4] == 4'd0);
      lead[BcdDigits-1-k] = upper_zero && (k != BcdDigits - 1);
    end
  end
`else
  assign lead = '0;
`endif

  assign presc_tc = (presc == PreW'(ScanTicks - 1));

  always_comb begin
    presc_nxt = presc_tc ? '0 : presc + 1'b1;
    idx_nxt   = idx;
    if (presc_tc) idx_nxt = (idx == IdxW'(Digits - 1)) ? '0 : idx + 1'b1;
  end

  // Segments are selected with the post-edge index so DigitSel and Segments move together.
  always_comb begin
    seg_sel = SEG_BLANK;
    if (valid) begin
      if (idx_nxt == IdxW'(Digits - 1)) seg_sel = disp_sign ? SEG_MINUS : SEG_BLANK;
      for (int unsigned p = 0; p < BcdDigits; p++) begin
        if (idx_nxt == IdxW'(p)) seg_sel = lead[p] ? SEG_BLANK : bcd_to_seg(disp_bcd[4*p +: 4]);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      valid     <= 1'b0;
      disp_bcd  <= '0;
      disp_sign <= 1'b0;
      presc     <= '0;
      idx       <= '0;
      Segments  <= SEG_BLANK;
      DigitSel  <= '1;
    end else begin
      if (done) begin
        valid     <= 1'b1;
        disp_bcd  <= bcd;
        disp_sign <= bcd_sign;
      end
      presc    <= presc_nxt;
      idx      <= idx_nxt;
      Segments <= seg_sel;
      DigitSel <= ~(Digits'(1) << idx_nxt);
    end
  end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Sequential display scheduler that shares one multiplexed common-anode seven-segment display between the digit positions of a number. The number is the magnitude plus separate sign bit produced by the data generator. The block converts the binary magnitude to BCD with a multi-cycle shift-add-3 converter, holds the result in a display register, and time-multiplexes the digits at a fixed scan rate. It sits between the data generator outputs and the board's segment/digit-select pins.

## Interface
- Size, 5, width of Data magnitude
- Digits, 3, display positions; position Digits-1 is the sign position; Digits-1 BCD positions must hold 2^Size-1
- ClockPeriod_ns, 20, Clock period
- ScanPeriod_ns, 1_000_000, dwell time per digit; ScanTicks = ScanPeriod_ns/ClockPeriod_ns (≥2)
- Clock  input  1  system clock, all logic on rising edge
- Reset  input  1  synchronous, active-high reset
- Data  input  Size  unsigned magnitude
- SigneBit  input  1  1 = negative
- Segments  output  7  {g,f,e,d,c,b,a}, active-low
- DigitSel  output  Digits  one-hot active-low digit enable
- Busy  output  1  conversion in progress

## Operation
- Reset values (Reset high at an edge):
  - Segments=7'h7F, DigitSel all ones, Busy=0.
  - Display register all blank, Valid=0, scan index 0, prescaler 0, FSM IDLE.
- FSM states and transitions:
  - IDLE→LOAD when Valid=0 or {SigneBit,Data} differs from the stored value.
  - LOAD: capture {SigneBit,Data} into the stored value; clear the BCD shift register; Busy=1.
  - SHIFT: Size cycles. Each cycle adds 3 to every BCD nibble ≥5, then shifts left one bit, bringing in the next magnitude MSB.
  - UPDATE: copy BCD and sign to the display register; Valid=1; Busy=0; →IDLE.
- {SigneBit,Data} changes during LOAD/SHIFT/UPDATE are ignored. They are detected in IDLE on the next cycle, which starts a new conversion.
- Sign position shows '-' (7'b0111111) when the stored SigneBit=1, otherwise blank (7'h7F). Sign is shown for magnitude 0 as well.
- Digit codes, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Scan:
  - Prescaler counts 0..ScanTicks-1. At terminal count it wraps to 0 and the index advances 0→1→…→Digits-1→0.
  - DigitSel=~(1<<index). Segments holds the code of display register position index.
- Reset mid-conversion aborts the conversion. No partial result ever reaches the display register.

## Timing
- Detection edge to display register update: Size+2 cycles (LOAD 1, SHIFT Size, UPDATE 1).
- Busy is high for exactly Size+2 cycles per conversion.
- Segments and DigitSel are both registered and change on the same edge. There is no one-cycle ghost of the previous digit.
- A display register update becomes visible at the current index on the edge after UPDATE. The index does not restart.
- First conversion after reset release: LOAD on the first edge with Reset low.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - BCD positions above the most significant non-zero digit show blank.
  - Position 0 always shows its digit.
  - The sign position is unaffected.
- Undefined: all BCD positions show their digit, including leading zeros.

## Structure
- Package display_scan_pkg holds:
  - FSM state enum (IDLE, LOAD, SHIFT, UPDATE)
  - segment constants SEG_BLANK and SEG_MINUS
  - function bcd_to_seg
- Sub-module bcd_converter: LOAD/SHIFT/UPDATE datapath with Start/Done handshake. Start is accepted only in IDLE; Done pulses for one cycle with the result.
- Top level holds change detection, display register, prescaler, scan index and output registers.

## Test plan
Bench parameters: Size=5, Digits=3, ClockPeriod_ns=20, ScanPeriod_ns=80, so ScanTicks=4.

- Reset held 3 cycles → Segments=7'h7F, DigitSel=3'b111, Busy=0. After release, Busy=1 for 7 cycles.
- Data=27, SigneBit=0 → position0=1111000, position1=0100100, position2=1111111.
- Data=5, SigneBit=1 → position0=0010010, position2=0111111. Position1=1111111 with LEADING_ZERO_BLANK_EN, 1000000 without.
- Data changes 27→9 on the 3rd Busy cycle → two back-to-back conversions, one IDLE cycle between. Final position0=0010000; position1 blank with LEADING_ZERO_BLANK_EN, 1000000 without.
- Steady Data over 24 cycles → DigitSel sequence 110,101,011,110,… each held exactly 4 cycles.
- Reset asserted mid-SHIFT → next edge gives reset values. The display register never shows the aborted value.
